// File: rtl/sram_lsu_master.sv
// sram_lsu_master: load/store bus initiator toward a single-cycle word SRAM.
// Takes one byte/half/word request at a time and returns a one-cycle response.
// Sub-word stores are performed as read-modify-write, because the responder
// only writes whole words. Rejected requests never touch the bus.
module sram_lsu_master #(
  parameter int unsigned MEM_WORDS = 8192
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        HSEL,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  state_t      state_r, state_n;
  logic [1:0]  lat_lane_r;
  logic [1:0]  lat_size_r;
  logic        lat_write_r;
  logic        lat_unsigned_r;
  logic [31:0] lat_wdata_r;

  logic        ready_r, resp_valid_r, resp_err_r, hsel_r, hwrite_r;
  logic [31:0] resp_rdata_r, haddr_r, hwdata_r;

  logic        accept_s;
  logic        req_err_s;

  // Replace the addressed byte or half of a word with right-aligned store data.
  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] m;
    m = old_word;
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   m[7:0]   = wdata[7:0];
          2'b01:   m[15:8]  = wdata[7:0];
          2'b10:   m[23:16] = wdata[7:0];
          2'b11:   m[31:24] = wdata[7:0];
          default: m        = old_word;
        endcase
      end
      2'b01: begin
        if (lane[1]) m[31:16] = wdata[15:0];
        else         m[15:0]  = wdata[15:0];
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  // Pick the addressed lane of a word and sign- or zero-extend it.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = is_unsigned ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = is_unsigned ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept_s  = (state_r == IDLE) && req_valid;
  assign req_err_s = (req_size == 2'b11) ||
                     ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                     ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  // Next-state decode: errors go straight to RESP, sub-word stores read first.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          if (req_err_s)                               state_n = RESP;
          else if (!req_write || (req_size != 2'b10))  state_n = RD;
          else                                         state_n = WR;
        end else begin
          state_n = IDLE;
        end
      end
      RD:      state_n = lat_write_r ? WR : RESP;
      WR:      state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and request latch.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r        <= IDLE;
      lat_lane_r     <= 2'b00;
      lat_size_r     <= 2'b00;
      lat_write_r    <= 1'b0;
      lat_unsigned_r <= 1'b0;
      lat_wdata_r    <= 32'h0000_0000;
    end else begin
      state_r <= state_n;
      if (accept_s) begin
        lat_lane_r     <= req_addr[1:0];
        lat_size_r     <= req_size;
        lat_write_r    <= req_write;
        lat_unsigned_r <= req_unsigned;
        lat_wdata_r    <= req_wdata;
      end else begin
        lat_lane_r     <= lat_lane_r;
        lat_size_r     <= lat_size_r;
        lat_write_r    <= lat_write_r;
        lat_unsigned_r <= lat_unsigned_r;
        lat_wdata_r    <= lat_wdata_r;
      end
    end
  end

  // Registered outputs, loaded from the state being entered; the word read
  // in RD is consumed at the RD exit edge (merge for stores, extract for loads).
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      hsel_r       <= 1'b0;
      hwrite_r     <= 1'b0;
      haddr_r      <= 32'h0000_0000;
      hwdata_r     <= 32'h0000_0000;
    end else begin
      ready_r      <= (state_n == IDLE);
      resp_valid_r <= (state_n == RESP);
      resp_err_r   <= accept_s && req_err_s;
      hsel_r       <= (state_n == RD) || (state_n == WR);
      hwrite_r     <= (state_n == WR);
      if ((state_r == RD) && !lat_write_r) begin
        resp_rdata_r <= extract_load(HRDATA, lat_lane_r, lat_size_r, lat_unsigned_r);
      end else begin
        resp_rdata_r <= 32'h0000_0000;
      end
      if (accept_s) begin
        haddr_r <= {req_addr[31:2], 2'b00};
      end else begin
        haddr_r <= haddr_r;
      end
      if (accept_s && (state_n == WR)) begin
        hwdata_r <= req_wdata;
      end else if ((state_r == RD) && lat_write_r) begin
        hwdata_r <= merge_store(HRDATA, lat_wdata_r, lat_lane_r, lat_size_r);
      end else begin
        hwdata_r <= hwdata_r;
      end
    end
  end

  assign req_ready  = ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = resp_rdata_r;
  assign HSEL       = hsel_r;
  assign HWRITE     = hwrite_r;
  assign HADDR      = haddr_r;
  assign HWDATA     = hwdata_r;

endmodule

// File: tb/tb_sram_lsu_master.sv
// Directed testbench for sram_lsu_master with a behavioural single-cycle SRAM.
module tb_sram_lsu_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:8191];
  logic        poke_en = 1'b0;
  logic [12:0] poke_idx = 13'd0;
  logic [31:0] poke_data = 32'h0;

  // results of the last do_req
  int          r_lat, r_wr_cnt;
  logic [31:0] r_rdata, r_waddr, r_wdata;
  logic        r_err, r_saw_sel, r_saw_rd, r_saw_wr;

  sram_lsu_master #(.MEM_WORDS(8192)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HWDATA(HWDATA), .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  assign HRDATA = (HSEL && !HWRITE) ? mem[HADDR[14:2]] : 32'h0;

  // SRAM write port, plus a backdoor preload port for the bench.
  always @(posedge HCLK) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    else if (HSEL && HWRITE) mem[HADDR[14:2]] <= HWDATA;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    @(negedge HCLK);
    poke_en = 1'b1; poke_idx = addr[14:2]; poke_data = data;
    @(posedge HCLK); #1;
    poke_en = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    @(negedge HCLK);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge HCLK); #1;
    req_valid = 1'b0;
    r_lat = 0; r_wr_cnt = 0; r_rdata = 32'hxxxx_xxxx; r_err = 1'bx;
    r_waddr = 32'h0; r_wdata = 32'h0;
    r_saw_sel = 1'b0; r_saw_rd = 1'b0; r_saw_wr = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge HCLK);
      if (HSEL) r_saw_sel = 1'b1;
      if (HSEL && !HWRITE) r_saw_rd = 1'b1;
      if (HSEL && HWRITE) begin
        r_saw_wr = 1'b1; r_wr_cnt++; r_waddr = HADDR; r_wdata = HWDATA;
      end
      if (resp_valid) begin
        r_lat = n; r_rdata = resp_rdata; r_err = resp_err;
        break;
      end
    end
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
    do_req(1'b0, sz, uns, addr, 32'h0);
    check_eq({tag, "_lat"}, r_lat, 2);
    check_eq({tag, "_rdata"}, r_rdata, exp);
    check_eq({tag, "_err"}, {31'h0, r_err}, 32'h0);
    check_eq({tag, "_nowrite"}, {31'h0, r_saw_wr}, 32'h0);
  endtask

  task automatic err_chk(input string tag, input logic w, input logic [1:0] sz,
                         input logic [31:0] addr);
    do_req(w, sz, 1'b0, addr, 32'h5555_5555);
    check_eq({tag, "_lat"}, r_lat, 1);
    check_eq({tag, "_err"}, {31'h0, r_err}, 32'h1);
    check_eq({tag, "_rdata"}, r_rdata, 32'h0);
    check_eq({tag, "_nosel"}, {31'h0, r_saw_sel}, 32'h0);
  endtask

  logic [31:0] qa [3];
  logic [31:0] qe [3];
  int acc, rsp, viol, stray;
  logic busy;

  initial begin
    HRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge HCLK);
    check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
    check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_eq("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_hsel", {31'h0, HSEL}, 32'h0);
    check_eq("rst_hwrite", {31'h0, HWRITE}, 32'h0);
    check_eq("rst_haddr", HADDR, 32'h0);
    check_eq("rst_hwdata", HWDATA, 32'h0);
    HRESET = 1'b0;

    // word store then load back
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
    check_eq("sw_lat", r_lat, 2);
    check_eq("sw_rdata", r_rdata, 32'h0);
    check_eq("sw_err", {31'h0, r_err}, 32'h0);
    check_eq("sw_wrcnt", r_wr_cnt, 1);
    check_eq("sw_haddr", r_waddr, 32'h10);
    check_eq("sw_hwdata", r_wdata, 32'hDEAD_BEEF);
    check_eq("sw_noread", {31'h0, r_saw_rd}, 32'h0);
    load_chk("lw10", 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);

    // byte store via read-modify-write
    poke(32'h20, 32'h1122_3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h22, 32'h0000_00AA);
    check_eq("sb_lat", r_lat, 3);
    check_eq("sb_read", {31'h0, r_saw_rd}, 32'h1);
    check_eq("sb_wrcnt", r_wr_cnt, 1);
    check_eq("sb_haddr", r_waddr, 32'h20);
    check_eq("sb_hwdata", r_wdata, 32'h11AA_3344);
    check_eq("sb_rdata", r_rdata, 32'h0);
    load_chk("lw20", 2'b10, 1'b0, 32'h20, 32'h11AA_3344);

    // half store, upper half
    poke(32'h50, 32'hCAFE_0123);
    do_req(1'b1, 2'b01, 1'b0, 32'h52, 32'h1234_BEEF);
    check_eq("sh_lat", r_lat, 3);
    check_eq("sh_hwdata", r_wdata, 32'hBEEF_0123);

    // sub-word load extension
    poke(32'h30, 32'h80FF_7F01);
    load_chk("lb31s", 2'b00, 1'b0, 32'h31, 32'h0000_007F);
    load_chk("lb32s", 2'b00, 1'b0, 32'h32, 32'hFFFF_FFFF);
    load_chk("lb33u", 2'b00, 1'b1, 32'h33, 32'h0000_0080);
    load_chk("lh32s", 2'b01, 1'b0, 32'h32, 32'hFFFF_80FF);
    load_chk("lh30u", 2'b01, 1'b1, 32'h30, 32'h0000_7F01);

    // last in-range word
    poke(32'h7FFC, 32'hA5A5_5A5A);
    load_chk("lwlast", 2'b10, 1'b0, 32'h7FFC, 32'hA5A5_5A5A);

    // rejected requests
    err_chk("e_half03", 1'b0, 2'b01, 32'h03);
    err_chk("e_word06", 1'b0, 2'b10, 32'h06);
    err_chk("e_size11", 1'b0, 2'b11, 32'h00);
    err_chk("e_oor", 1'b0, 2'b10, 32'h8000);
    err_chk("e_st_mis", 1'b1, 2'b10, 32'h41);

    // reset during the read phase of an RMW
    poke(32'h40, 32'h1234_5678);
    @(negedge HCLK);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h42; req_wdata = 32'h0000_BEEF;
    @(posedge HCLK); #1;
    req_valid = 1'b0;
    @(negedge HCLK);
    check_eq("mr_in_rd", {30'h0, HSEL, HWRITE}, 32'h2);
    HRESET = 1'b1;
    #1;
    check_eq("mr_hsel", {31'h0, HSEL}, 32'h0);
    check_eq("mr_ready", {31'h0, req_ready}, 32'h1);
    check_eq("mr_resp_valid", {31'h0, resp_valid}, 32'h0);
    check_eq("mr_haddr", HADDR, 32'h0);
    check_eq("mr_hwdata", HWDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    stray = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge HCLK);
      if (resp_valid || HSEL) stray++;
    end
    check_eq("mr_no_activity", stray, 0);
    check_eq("mr_mem", mem[16], 32'h1234_5678);
    load_chk("mr_after", 2'b10, 1'b0, 32'h40, 32'h1234_5678);

    // back-to-back loads with req_valid held high
    qa[0] = 32'h10; qa[1] = 32'h20; qa[2] = 32'h30;
    qe[0] = 32'hDEAD_BEEF; qe[1] = 32'h11AA_3344; qe[2] = 32'h80FF_7F01;
    acc = 0; rsp = 0; viol = 0; busy = 1'b0;
    @(negedge HCLK);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = qa[0];
    for (int n = 0; n < 40 && rsp < 3; n++) begin
      if (resp_valid) begin
        check_eq($sformatf("q%0d_rdata", rsp), resp_rdata, qe[rsp]);
        if (req_ready) viol++;
        rsp++;
        busy = 1'b0;
        if (rsp < 3) req_addr = qa[rsp];
        else req_valid = 1'b0;
      end else if (busy) begin
        if (req_ready) viol++;
      end else if (req_ready && req_valid) begin
        acc++;
        busy = 1'b1;
      end
      @(negedge HCLK);
    end
    req_valid = 1'b0;
    check_eq("q_accepts", acc, 3);
    check_eq("q_responses", rsp, 3);
    check_eq("q_ready_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_lsu_master.md
Name: sram_lsu_master

Overview:
- Bus initiator between the CPU load/store unit and the single-cycle SRAM responder; drives HSEL/HADDR/HWRITE/HWDATA and samples HRDATA.
- Accepts one byte, half or word load/store at a time on a valid/ready request channel and returns a one-cycle response.
- The responder only writes whole words, so sub-word stores are done as a read-modify-write (RMW).
- Misaligned, illegal-size and out-of-range requests get an error response and cause no bus activity.

Parameters:
MEM_WORDS, 8192, number of 32-bit words behind the responder; a request with word index (req_addr[31:2]) >= MEM_WORDS is out of range.

Ports:
HCLK  input  1  system clock, rising edge
HRESET  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle response strobe
resp_err  output  1  qualifies resp_valid: request rejected
resp_rdata  output  32  extended load data; 0 for stores and errors
HSEL  output  1  responder select
HADDR  output  32  word-aligned byte address: {lat_addr[31:2],2'b00}
HWRITE  output  1  write strobe (responder writes at posedge while HSEL&HWRITE)
HWDATA  output  32  write word
HRDATA  input  32  combinational read data, valid while HSEL=1 and HWRITE=0

Behaviour:
- Clock and reset: one clock HCLK; HRESET is asynchronous, active-high. All flops reset asynchronously.
- Reset outputs: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, HSEL=0, HWRITE=0, HADDR=0, HWDATA=0.
- Output timing: all outputs decode from the state register and latched request fields only; there is no combinational path from req_* to bus outputs.
- FSM states: IDLE, RD, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a posedge, latch addr, wdata, size, write and unsigned.
  - Compute err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (addr[31:2] >= MEM_WORDS).
  - Next state: err -> RESP with err flag; load or sub-word store -> RD; word store -> WR.
- RD:
  - HSEL=1, HWRITE=0; capture HRDATA into rbuf at the posedge.
  - Next: load -> RESP; store -> WR.
- WR:
  - HSEL=1, HWRITE=1, HWDATA=merged word; next -> RESP.
  - Word store: merged = wdata.
  - Byte store: rbuf with lane addr[1:0] (bits 8*k+7:8*k) replaced by wdata[7:0].
  - Half store: rbuf with half addr[1] replaced by wdata[15:0].
  - Lanes are little-endian.
- RESP:
  - resp_valid=1 for exactly one cycle; next -> IDLE. No backpressure: the consumer must take the response.
  - resp_err=1 only for rejected requests.
  - Load response: the lane selected by addr is extracted from rbuf, then sign- or zero-extended to 32 bits.
- Latency, counted in cycles after the acceptance edge until resp_valid:
  - error: 1
  - load: 2
  - word store: 2
  - sub-word store: 3
- Throughput: req_ready returns high the cycle after RESP, so back-to-back requests are separated by at least one IDLE cycle.
- Bus outputs in IDLE and RESP: HSEL=0, HWRITE=0, HADDR and HWDATA hold their last values (not required to be zero).
- Reset mid-operation:
  - Immediate return to IDLE with HSEL=0; the request is dropped and no response is issued.
  - Reset during RD leaves memory unchanged. A write is only ever issued in WR, so an interrupted RMW never writes a partial word.
- Loads never assert HWRITE. Error requests never assert HSEL.

Test Plan:
- Word store addr 0x10 data 0xDEADBEEF, then word load addr 0x10 -> store: one WR cycle (HADDR=0x10), resp_valid 2 cycles after accept, rdata 0. Load: resp_rdata=0xDEADBEEF, resp_err=0.
- Memory[0x20]=0x11223344; byte store addr 0x22 data 0xAA -> RD then WR with HWDATA=0x11AA3344, resp 3 cycles after accept; word load -> 0x11AA3344.
- Memory[0x30]=0x80FF7F01; loads: byte 0x31 signed -> 0x0000007F; byte 0x32 signed -> 0xFFFFFFFF; byte 0x33 unsigned -> 0x00000080; half 0x32 signed -> 0xFFFF80FF.
- Half load at 0x03, word load at 0x06, req_size=11, word load at MEM_WORDS*4 -> each: resp_valid with resp_err=1 one cycle after accept, resp_rdata=0, HSEL never asserted.
- Half store at 0x42 data 0xBEEF, HRESET pulsed during RD -> outputs return to reset values asynchronously; no resp_valid; memory[0x40] unchanged; the next request completes normally.
- req_valid held high with 3 queued loads -> req_ready low from accept to the end of RESP; each request accepted exactly once; responses in order, one per request.
